// File: rtl/nic_chan_pkg.sv
// Shared constants, channel/flow-ctrl field map and FSM state
// for the NIC injection transmitter.
package nic_chan_pkg;

   localparam int NUM_VCS         = 4;
   localparam int BUFFER_SIZE     = 64;
   localparam int CREDITS_PER_VC  = BUFFER_SIZE / NUM_VCS;
   localparam int FLIT_DATA_WIDTH = 64;
   localparam int MAX_PAYLOAD     = 4;
   localparam int DEST_WIDTH      = 4;
   localparam int LEN_WIDTH       = 3;
   localparam int VC_WIDTH        = 2;
   localparam int CTR_WIDTH       = 5;

   localparam int CH_WIDTH = 6 + FLIT_DATA_WIDTH;
   localparam int CH_LINK  = 0;
   localparam int CH_VALID = 1;
   localparam int CH_HEAD  = 2;
   localparam int CH_TAIL  = 3;
   localparam int CH_VC    = 4;
   localparam int CH_DATA  = 6;

   localparam int FC_WIDTH = 3;
   localparam int FC_VALID = 0;
   localparam int FC_VC    = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HEAD = 2'd1,
      BODY = 2'd2
   } state_t;

   function automatic logic [LEN_WIDTH-1:0] clamp_len(
      input logic [LEN_WIDTH-1:0] len
   );
      return (len > LEN_WIDTH'(MAX_PAYLOAD)) ?
         LEN_WIDTH'(MAX_PAYLOAD) : len;
   endfunction

endpackage

// File: rtl/nic_channel_tx_if.sv
// Host command/data, router channel and flow-ctrl bundle.
// slave = transmitter side, master = host/router side.
interface nic_channel_tx_if;
   import nic_chan_pkg::*;

   logic                       pkt_valid;
   logic                       pkt_ready;
   logic [DEST_WIDTH-1:0]      pkt_dest;
   logic [LEN_WIDTH-1:0]       pkt_len;
   logic                       data_valid;
   logic                       data_ready;
   logic [FLIT_DATA_WIDTH-1:0] data_in;
   logic [CH_WIDTH-1:0]        channel_out;
   logic [FC_WIDTH-1:0]        flow_ctrl_in;
   logic                       error;

   modport slave (
      input  pkt_valid, pkt_dest, pkt_len,
      input  data_valid, data_in, flow_ctrl_in,
      output pkt_ready, data_ready, channel_out, error
   );

   modport master (
      output pkt_valid, pkt_dest, pkt_len,
      output data_valid, data_in, flow_ctrl_in,
      input  pkt_ready, data_ready, channel_out, error
   );

endinterface

// File: rtl/nic_credit_ctr.sv
// Saturating 0..CREDITS_PER_VC credit counter for one VC.
// A same-cycle inc and dec cancel out.
module nic_credit_ctr
   import nic_chan_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 inc,
   input  logic                 dec,
   output logic [CTR_WIDTH-1:0] count,
   output logic                 full,
   output logic                 empty,
   output logic                 overflow
);

   assign full     = (count == CTR_WIDTH'(CREDITS_PER_VC));
   assign empty    = (count == '0);
   assign overflow = inc && !dec && full;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= CTR_WIDTH'(CREDITS_PER_VC);
      end else if (inc && !dec && !full) begin
         count <= count + CTR_WIDTH'(1);
      end else if (dec && !inc && !empty) begin
         count <= count - CTR_WIDTH'(1);
      end
   end

endmodule

// File: rtl/nic_channel_tx.sv
// NIC injection transmitter: packet segmentation, round-robin VC pick,
// per-VC credits. `NIC_LINK_PM_EN enables link_active power management.
module nic_channel_tx
   import nic_chan_pkg::*;
(
   input logic             clk,
   input logic             reset,
   nic_channel_tx_if.slave bus
);

   state_t state, state_nxt;

   logic [VC_WIDTH-1:0]        vc_q, rr_q, pick, idx;
   logic                       pick_ok;
   logic [DEST_WIDTH-1:0]      dest_q;
   logic [LEN_WIDTH-1:0]       len_q, cnt_q;
   logic                       run_q, error_q, link;

   logic [NUM_VCS-1:0]         inc, dec, full, empty, ovf;
   logic [CTR_WIDTH-1:0]       credit [NUM_VCS];

   logic                       accept, head_fire, body_fire, body_last;
   logic                       f_valid, f_head, f_tail;
   logic [VC_WIDTH-1:0]        f_vc;
   logic [FLIT_DATA_WIDTH-1:0] f_data;

   logic                       ch_valid, ch_head, ch_tail;
   logic [VC_WIDTH-1:0]        ch_vc;
   logic [FLIT_DATA_WIDTH-1:0] ch_data;

   for (genvar g = 0; g < NUM_VCS; g++) begin : g_ctr
      nic_credit_ctr u_ctr (
         .clk      (clk),
         .reset    (reset),
         .inc      (inc[g]),
         .dec      (dec[g]),
         .count    (credit[g]),
         .full     (full[g]),
         .empty    (empty[g]),
         .overflow (ovf[g])
      );
   end

   // lowest offset from rr_q wins, so scan from the far end
   always_comb begin
      pick    = '0;
      pick_ok = 1'b0;
      idx     = '0;
      for (int k = NUM_VCS - 1; k >= 0; k--) begin
         idx = rr_q + VC_WIDTH'(k);
         if (!empty[idx]) begin
            pick    = idx;
            pick_ok = 1'b1;
         end
      end
   end

   assign bus.pkt_ready  = run_q && (state == IDLE) && pick_ok;
   assign bus.data_ready = (state == BODY) && !empty[vc_q];

   assign accept    = bus.pkt_valid && bus.pkt_ready;
   assign head_fire = (state == HEAD);
   assign body_fire = bus.data_valid && bus.data_ready;
   assign body_last = ((cnt_q + LEN_WIDTH'(1)) == len_q);

   always_comb begin
      inc = '0;
      dec = '0;
      for (int i = 0; i < NUM_VCS; i++) begin
         inc[i] = bus.flow_ctrl_in[FC_VALID] &&
            (bus.flow_ctrl_in[FC_VC +: VC_WIDTH] == VC_WIDTH'(i));
         dec[i] = (head_fire || body_fire) &&
            (vc_q == VC_WIDTH'(i));
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept) state_nxt = HEAD;
         HEAD: state_nxt = (len_q == '0) ? IDLE : BODY;
         BODY: if (body_fire && body_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      f_valid = head_fire || body_fire;
      f_head  = head_fire;
      f_tail  = 1'b0;
      f_vc    = '0;
      f_data  = '0;
      if (head_fire) begin
         f_tail = (len_q == '0);
         f_vc   = vc_q;
         f_data = {dest_q, len_q,
            {(FLIT_DATA_WIDTH - DEST_WIDTH - LEN_WIDTH){1'b0}}};
      end else if (body_fire) begin
         f_tail = body_last;
         f_vc   = vc_q;
         f_data = bus.data_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_q    <= 1'b0;
         error_q  <= 1'b0;
         vc_q     <= '0;
         rr_q     <= '0;
         dest_q   <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         ch_valid <= 1'b0;
         ch_head  <= 1'b0;
         ch_tail  <= 1'b0;
         ch_vc    <= '0;
         ch_data  <= '0;
      end else begin
         run_q   <= 1'b1;
         error_q <= error_q | (|ovf);
         if (accept) begin
            vc_q   <= pick;
            rr_q   <= pick + VC_WIDTH'(1);
            dest_q <= bus.pkt_dest;
            len_q  <= clamp_len(bus.pkt_len);
            cnt_q  <= '0;
         end else if (body_fire) begin
            cnt_q <= cnt_q + LEN_WIDTH'(1);
         end
         ch_valid <= f_valid;
         ch_head  <= f_head;
         ch_tail  <= f_tail;
         ch_vc    <= f_vc;
         ch_data  <= f_data;
      end
   end

`ifdef NIC_LINK_PM_EN
   logic link_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) link_q <= 1'b0;
      else link_q <= (state != IDLE) || !(&full) || bus.pkt_valid;
   end

   assign link = link_q;
`else
   logic full_unused;

   assign full_unused = &full;
   assign link        = 1'b1;
`endif

   assign bus.channel_out = {ch_data, ch_vc, ch_tail,
                             ch_head, ch_valid, link};
   assign bus.error       = error_q;

endmodule

// File: tb/tb_nic_channel_tx.sv
// Directed bench for nic_channel_tx: vector table plus
// hand-written multi-cycle sequences.
module tb_nic_channel_tx;
   import nic_chan_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   nic_channel_tx_if bus ();

   nic_channel_tx dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

`ifdef NIC_LINK_PM_EN
   localparam logic LINK_IDLE = 1'b0;
`else
   localparam logic LINK_IDLE = 1'b1;
`endif

   int checks = 0;
   int errors = 0;
   logic [CH_WIDTH-1:0] flits [$];

   typedef struct {
      logic [3:0] dest;
      logic [1:0] vc;
      int         cr;
   } vec_t;

   vec_t tbl [5];
   logic [63:0] words [4];

   always @(posedge clk) begin
      #1;
      if (reset && bus.channel_out[CH_VALID])
         flits.push_back(bus.channel_out);
   end

   task automatic chk_w(input string nm,
                        input logic [CH_WIDTH-1:0] act,
                        input logic [CH_WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_n(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic chk_cr(input string nm, input int vc, input int exp);
      chk_n(nm, int'(dut.credit[vc]), exp);
   endtask

   function automatic logic [CH_WIDTH-1:0] mk(
      input logic head, input logic tail,
      input logic [1:0] vc, input logic [63:0] d);
      return {d, vc, tail, head, 1'b1, 1'b1};
   endfunction

   function automatic logic [63:0] hdr(input logic [3:0] dest,
                                       input logic [2:0] len);
      return {dest, len, 57'd0};
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_inputs();
      bus.pkt_valid    = 1'b0;
      bus.pkt_dest     = '0;
      bus.pkt_len      = '0;
      bus.data_valid   = 1'b0;
      bus.data_in      = '0;
      bus.flow_ctrl_in = '0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      clear_inputs();
      tick(2);
      reset = 1'b1;
      tick(2);
      flits.delete();
   endtask

   task automatic send_pkt(input logic [3:0] d, input logic [2:0] l);
      int n = 0;
      while (!bus.pkt_ready && n < 20) begin
         tick();
         n++;
      end
      chk_n("pkt_ready", int'(bus.pkt_ready), 1);
      bus.pkt_valid = 1'b1;
      bus.pkt_dest  = d;
      bus.pkt_len   = l;
      tick();
      bus.pkt_valid = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.data_ready && n < 20) begin
         tick();
         n++;
      end
      chk_n("data_ready", int'(bus.data_ready), 1);
   endtask

   task automatic feed(input int n, input int first);
      for (int i = 0; i < n; i++) begin
         wait_ready();
         bus.data_valid = 1'b1;
         bus.data_in    = words[first + i];
         tick();
         bus.data_valid = 1'b0;
         tick();
      end
   endtask

   task automatic wait_flits(input int n);
      int k = 0;
      while (flits.size() < n && k < 60) begin
         tick();
         k++;
      end
      chk_n("flit_count", flits.size(), n);
   endtask

   task automatic ret_credit(input logic [1:0] vc);
      bus.flow_ctrl_in = {vc, 1'b1};
      tick();
      bus.flow_ctrl_in = '0;
   endtask

   initial begin
      tbl[0] = '{dest: 4'd5,  vc: 2'd0, cr: 15};
      tbl[1] = '{dest: 4'd9,  vc: 2'd1, cr: 15};
      tbl[2] = '{dest: 4'd3,  vc: 2'd2, cr: 15};
      tbl[3] = '{dest: 4'd15, vc: 2'd3, cr: 15};
      tbl[4] = '{dest: 4'd0,  vc: 2'd0, cr: 14};
      words[0] = 64'hAAAA_0000_1111_0001;
      words[1] = 64'hBBBB_0000_2222_0002;
      words[2] = 64'hCCCC_0000_3333_0003;
      words[3] = 64'hDDDD_0000_4444_0004;

      // reset state
      clear_inputs();
      tick(2);
      chk_w("rst_channel", bus.channel_out, {69'd0, LINK_IDLE});
      chk_n("rst_pkt_ready", int'(bus.pkt_ready), 0);
      chk_n("rst_data_ready", int'(bus.data_ready), 0);
      chk_n("rst_error", int'(bus.error), 0);
      for (int v = 0; v < NUM_VCS; v++) chk_cr("rst_credit", v, 16);
      reset = 1'b1;
      tick(2);
      flits.delete();

      // single-flit packets, round-robin VC
      for (int i = 0; i < 5; i++) begin
         flits.delete();
         send_pkt(tbl[i].dest, 3'd0);
         wait_flits(1);
         chk_w("t1_flit", flits[0],
               mk(1'b1, 1'b1, tbl[i].vc, hdr(tbl[i].dest, 3'd0)));
         chk_cr("t1_credit", int'(tbl[i].vc), tbl[i].cr);
      end

      // len=4 with data_valid gaps on vc1
      flits.delete();
      send_pkt(4'hA, 3'd4);
      feed(4, 0);
      wait_flits(5);
      chk_w("t2_head", flits[0], mk(1'b1, 1'b0, 2'd1, hdr(4'hA, 3'd4)));
      for (int i = 0; i < 4; i++)
         chk_w("t2_body", flits[1 + i],
               mk(1'b0, i == 3, 2'd1, words[i]));
      chk_cr("t2_credit", 1, 10);

      // len=6 clamps to 4 body flits on vc2
      flits.delete();
      send_pkt(4'h6, 3'd6);
      feed(4, 0);
      wait_flits(5);
      tick(4);
      chk_n("clamp_count", flits.size(), 5);
      chk_w("clamp_head", flits[0], mk(1'b1, 1'b0, 2'd2, hdr(4'h6, 3'd4)));
      chk_w("clamp_tail", flits[4], mk(1'b0, 1'b1, 2'd2, words[3]));
      chk_n("clamp_idle", int'(bus.data_ready), 0);

      // same-cycle return and send on vc3
      flits.delete();
      send_pkt(4'h3, 3'd2);
      wait_ready();
      bus.data_valid   = 1'b1;
      bus.data_in      = words[1];
      bus.flow_ctrl_in = {2'd3, 1'b1};
      tick();
      bus.data_valid   = 1'b0;
      bus.flow_ctrl_in = '0;
      chk_cr("t4_same_cycle", 3, 14);
      chk_n("t4_error", int'(bus.error), 0);
      feed(1, 2);
      wait_flits(3);
      chk_w("t4_body1", flits[1], mk(1'b0, 1'b0, 2'd3, words[1]));
      chk_w("t4_tail", flits[2], mk(1'b0, 1'b1, 2'd3, words[2]));
      chk_cr("t4_credit_end", 3, 13);

      // credit return at full -> sticky error
      do_reset();
      ret_credit(2'd2);
      chk_n("t5_error", int'(bus.error), 1);
      chk_cr("t5_credit", 2, 16);
      tick(3);
      chk_n("t5_error_sticky", int'(bus.error), 1);

      // drain all credits; 65th packet stalls
      flits.delete();
      for (int i = 0; i < 64; i++) send_pkt(4'(i), 3'd0);
      wait_flits(64);
      tick(2);
      chk_n("t3_stall", int'(bus.pkt_ready), 0);
      for (int i = 0; i < 64; i++)
         chk_w("t3_flit", flits[i],
               mk(1'b1, 1'b1, 2'(i % 4), hdr(4'(i), 3'd0)));
      for (int v = 0; v < NUM_VCS; v++) chk_cr("t3_empty", v, 0);
      ret_credit(2'd3);
      chk_n("t3_resume", int'(bus.pkt_ready), 1);
      send_pkt(4'h7, 3'd0);
      wait_flits(65);
      chk_w("t3_resume_flit", flits[64],
            mk(1'b1, 1'b1, 2'd3, hdr(4'h7, 3'd0)));
      chk_n("t3_error_kept", int'(bus.error), 1);

      // reset mid-BODY drops the packet
      do_reset();
      chk_n("t6_error_clr", int'(bus.error), 0);
      send_pkt(4'h9, 3'd4);
      feed(2, 0);
      wait_flits(3);
      reset = 1'b0;
      #1;
      chk_w("t6_channel", bus.channel_out, {69'd0, LINK_IDLE});
      chk_n("t6_data_ready", int'(bus.data_ready), 0);
      for (int v = 0; v < NUM_VCS; v++) chk_cr("t6_credit", v, 16);
      tick();
      reset = 1'b1;
      tick(3);
      chk_n("t6_pkt_ready", int'(bus.pkt_ready), 1);
      chk_n("t6_link", int'(bus.channel_out[CH_LINK]), int'(LINK_IDLE));
      chk_n("t6_no_tail", flits.size(), 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
